// File: rtl/timer_bank.sv
// Multi-channel programmable interval timer.
// A single free-running prescaler produces a shared tick. Each channel has an
// up-counter that compares against its own value, reloads to zero on a hit,
// and optionally stops after the first hit (one-shot). A hit sets a sticky
// interrupt that stays pending until it is acknowledged.
module timer_bank #(
  parameter int CPU_WIDTH = 16,
  parameter int CNT_WIDTH = 26,
  parameter int NUM_CH    = 2,
  parameter int PSC_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PSC_WIDTH-1:0]          psc,
  input  logic [NUM_CH-1:0]             en,
  input  logic [NUM_CH-1:0]             mode,
  input  logic [NUM_CH-1:0]             load,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   cmp,
  input  logic [NUM_CH-1:0]             irq_ack,
  output logic [NUM_CH-1:0]             irq,
  output logic [NUM_CH-1:0]             running,
  output logic [NUM_CH*CPU_WIDTH-1:0]   count
);

  logic [PSC_WIDTH-1:0] psc_cnt;
  logic                 tick;

  // Tick when the prescaler reaches the divide value. If psc is lowered
  // below the current psc_cnt, the counter simply runs on and wraps to 0.
  assign tick = (psc_cnt == psc);

  // Shared prescaler: free-running, cleared on every tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      psc_cnt <= '0;
    end else if (tick) begin
      psc_cnt <= '0;
    end else begin
      psc_cnt <= psc_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_WIDTH-1:0] cnt_r;
    logic                 run_r;
    logic                 irq_r;
    logic [CNT_WIDTH-1:0] cmp_ch;
    logic                 adv;
    logic                 hit;

    assign cmp_ch = cmp[i*CNT_WIDTH +: CNT_WIDTH];
    // A counting opportunity for this channel; load takes precedence, so a
    // load edge never produces a hit.
    assign adv    = en[i] & run_r & tick & ~load[i];
    assign hit    = adv & (cnt_r == cmp_ch);

    // Counter and armed flag: load, then hit, then plain increment.
    // Counting past a lowered compare value wraps naturally with no hit.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_r <= '0;
        run_r <= 1'b1;
      end else if (load[i]) begin
        cnt_r <= '0;
        run_r <= 1'b1;
      end else if (hit) begin
        cnt_r <= '0;
        if (mode[i]) begin
          run_r <= 1'b0;
        end
      end else if (adv) begin
        cnt_r <= cnt_r + 1'b1;
      end
    end

    // Sticky interrupt: a hit wins over a simultaneous acknowledge.
    always_ff @(posedge clk) begin
      if (rst) begin
        irq_r <= 1'b0;
      end else if (hit) begin
        irq_r <= 1'b1;
      end else if (irq_ack[i]) begin
        irq_r <= 1'b0;
      end
    end

    assign irq[i]     = irq_r;
    assign running[i] = run_r;

    if (CPU_WIDTH > CNT_WIDTH) begin : g_ext
      assign count[i*CPU_WIDTH +: CPU_WIDTH] = {{(CPU_WIDTH-CNT_WIDTH){1'b0}}, cnt_r};
    end else begin : g_trunc
      assign count[i*CPU_WIDTH +: CPU_WIDTH] = cnt_r[CPU_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank: fixed vector table, hand-written corner sequences and
// randomized traffic, all compared against a small behavioural model.
module tb_timer_bank;

  localparam int CPW = 16;
  localparam int CW  = 4;
  localparam int NCH = 2;
  localparam int PW  = 4;
  localparam int CMOD = 16;   // 2**CW
  localparam int PMOD = 16;   // 2**PW

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [PW-1:0]   psc = '0;
  logic [NCH-1:0]  en = '0;
  logic [NCH-1:0]  mode = '0;
  logic [NCH-1:0]  load = '0;
  logic [NCH*CW-1:0] cmp = '0;
  logic [NCH-1:0]  irq_ack = '0;
  logic [NCH-1:0]  irq;
  logic [NCH-1:0]  running;
  logic [NCH*CPW-1:0] count;

  timer_bank #(
    .CPU_WIDTH(CPW),
    .CNT_WIDTH(CW),
    .NUM_CH(NCH),
    .PSC_WIDTH(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .psc(psc),
    .en(en),
    .mode(mode),
    .load(load),
    .cmp(cmp),
    .irq_ack(irq_ack),
    .irq(irq),
    .running(running),
    .count(count)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Behavioural model state
  int m_psc;
  int m_cnt [NCH];
  bit m_run [NCH];
  bit m_irq [NCH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the current inputs.
  task automatic model_step();
    bit tk;
    int c;
    if (rst) begin
      m_psc = 0;
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] = 0;
        m_run[i] = 1'b1;
        m_irq[i] = 1'b0;
      end
    end else begin
      tk = (m_psc == int'(psc));
      m_psc = tk ? 0 : (m_psc + 1) % PMOD;
      for (int i = 0; i < NCH; i++) begin
        bit h;
        h = 1'b0;
        c = int'(cmp[i*CW +: CW]);
        if (load[i]) begin
          m_cnt[i] = 0;
          m_run[i] = 1'b1;
        end else if (en[i] && m_run[i] && tk) begin
          if (m_cnt[i] == c) begin
            h = 1'b1;
            m_cnt[i] = 0;
            if (mode[i]) m_run[i] = 1'b0;
          end else begin
            m_cnt[i] = (m_cnt[i] + 1) % CMOD;
          end
        end
        if (h) m_irq[i] = 1'b1;
        else if (irq_ack[i]) m_irq[i] = 1'b0;
      end
    end
  endtask

  // One clock edge followed by a full model comparison.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("model_irq", 32'(irq), {30'b0, m_irq[1], m_irq[0]});
    chk("model_running", 32'(running), {30'b0, m_run[1], m_run[0]});
    chk("model_count0", 32'(count[15:0]), m_cnt[0]);
    chk("model_count1", 32'(count[31:16]), m_cnt[1]);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] psc;
    logic [1:0] en;
    logic [1:0] mode;
    logic [1:0] load;
    logic [1:0] ack;
    logic [3:0] c0;
    logic [3:0] c1;
    logic [1:0] e_irq;
    logic [1:0] e_run;
    logic [3:0] e_c0;
    logic [3:0] e_c1;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic [3:0] p, input logic [1:0] e,
                              input logic [1:0] m, input logic [1:0] l, input logic [1:0] a,
                              input logic [3:0] c0, input logic [3:0] c1,
                              input logic [1:0] xi, input logic [1:0] xr,
                              input logic [3:0] x0, input logic [3:0] x1);
    vec_t v;
    v.rst = r; v.psc = p; v.en = e; v.mode = m; v.load = l; v.ack = a;
    v.c0 = c0; v.c1 = c1; v.e_irq = xi; v.e_run = xr; v.e_c0 = x0; v.e_c1 = x1;
    tbl.push_back(v);
  endfunction

  initial begin
    // Auto-reload channel 0, cmp=3, psc=0; ack timing and ack-vs-hit
    //   rst psc en mode load ack c0 c1  irq run cnt0 cnt1
    add(1, 0, 0, 0, 0, 0, 3, 1,  0, 3, 0, 0);
    add(0, 0, 1, 0, 0, 0, 3, 1,  0, 3, 1, 0);
    add(0, 0, 1, 0, 0, 0, 3, 1,  0, 3, 2, 0);
    add(0, 0, 1, 0, 0, 0, 3, 1,  0, 3, 3, 0);
    add(0, 0, 1, 0, 0, 0, 3, 1,  1, 3, 0, 0);
    add(0, 0, 1, 0, 0, 0, 3, 1,  1, 3, 1, 0);
    add(0, 0, 1, 0, 0, 1, 3, 1,  0, 3, 2, 0);
    add(0, 0, 1, 0, 0, 0, 3, 1,  0, 3, 3, 0);
    add(0, 0, 1, 0, 0, 0, 3, 1,  1, 3, 0, 0);
    add(0, 0, 1, 0, 0, 0, 3, 1,  1, 3, 1, 0);
    add(0, 0, 1, 0, 0, 0, 3, 1,  1, 3, 2, 0);
    add(0, 0, 1, 0, 0, 0, 3, 1,  1, 3, 3, 0);
    add(0, 0, 1, 0, 0, 1, 3, 1,  1, 3, 0, 0);
    // One-shot channel 1, psc=2, cmp=1; then reload with load
    add(1, 2, 0, 2, 0, 0, 3, 1,  0, 3, 0, 0);
    add(0, 2, 2, 2, 0, 0, 3, 1,  0, 3, 0, 0);
    add(0, 2, 2, 2, 0, 0, 3, 1,  0, 3, 0, 0);
    add(0, 2, 2, 2, 0, 0, 3, 1,  0, 3, 0, 1);
    add(0, 2, 2, 2, 0, 0, 3, 1,  0, 3, 0, 1);
    add(0, 2, 2, 2, 0, 0, 3, 1,  0, 3, 0, 1);
    add(0, 2, 2, 2, 0, 0, 3, 1,  2, 1, 0, 0);
    add(0, 2, 2, 2, 0, 0, 3, 1,  2, 1, 0, 0);
    add(0, 2, 2, 2, 2, 0, 3, 1,  2, 3, 0, 0);
    add(0, 2, 2, 2, 0, 0, 3, 1,  2, 3, 0, 1);
    add(0, 2, 2, 2, 0, 0, 3, 1,  2, 3, 0, 1);
    add(0, 2, 2, 2, 0, 0, 3, 1,  2, 3, 0, 1);
    add(0, 2, 2, 2, 0, 0, 3, 1,  2, 1, 0, 0);

    for (int k = 0; k < tbl.size(); k++) begin
      rst = tbl[k].rst; psc = tbl[k].psc; en = tbl[k].en; mode = tbl[k].mode;
      load = tbl[k].load; irq_ack = tbl[k].ack; cmp = {tbl[k].c1, tbl[k].c0};
      cyc();
      chk($sformatf("tbl%0d_irq", k), 32'(irq), 32'(tbl[k].e_irq));
      chk($sformatf("tbl%0d_running", k), 32'(running), 32'(tbl[k].e_run));
      chk($sformatf("tbl%0d_count0", k), 32'(count[15:0]), 32'(tbl[k].e_c0));
      chk($sformatf("tbl%0d_count1", k), 32'(count[31:16]), 32'(tbl[k].e_c1));
    end
    load = '0; irq_ack = '0;

    // Enable gating holds the count; load works with the channel disabled
    rst = 1; psc = 0; en = 0; mode = 0; cmp = {4'd1, 4'd10};
    cyc();
    rst = 0; en = 2'b01;
    cyc(); cyc();
    chk("t4_count_before_hold", 32'(count[15:0]), 2);
    en = 2'b00;
    repeat (5) begin
      cyc();
      chk("t4_hold", 32'(count[15:0]), 2);
    end
    en = 2'b01;
    cyc();
    chk("t4_resume", 32'(count[15:0]), 3);
    en = 2'b00; load = 2'b01;
    cyc();
    load = 2'b00;
    chk("t4_load_disabled", 32'(count[15:0]), 0);
    chk("t4_load_running", 32'(running[0]), 1);

    // Compare lowered below the count: wrap through 15 without an irq
    rst = 1; cmp = {4'd1, 4'd10};
    cyc();
    rst = 0; en = 2'b01;
    repeat (5) cyc();
    chk("t5_count5", 32'(count[15:0]), 5);
    cmp[3:0] = 4'd1;
    repeat (10) cyc();
    chk("t5_count15", 32'(count[15:0]), 15);
    cyc();
    chk("t5_wrap0", 32'(count[15:0]), 0);
    chk("t5_wrap_noirq", 32'(irq[0]), 0);
    cyc();
    chk("t5_count1", 32'(count[15:0]), 1);
    cyc();
    chk("t5_hit_count", 32'(count[15:0]), 0);
    chk("t5_hit_irq", 32'(irq[0]), 1);

    // Reset mid-count with irq pending, overriding load and enables
    cmp = {4'd9, 4'd10}; en = 2'b11;
    cyc(); cyc();
    chk("t6_pre_count0", 32'(count[15:0]), 2);
    chk("t6_pre_irq", 32'(irq[0]), 1);
    rst = 1; load = 2'b11; psc = 3;
    cyc();
    rst = 0; load = 2'b00;
    chk("t6_irq", 32'(irq), 0);
    chk("t6_running", 32'(running), 3);
    chk("t6_count0", 32'(count[15:0]), 0);
    chk("t6_count1", 32'(count[31:16]), 0);
    repeat (3) begin
      cyc();
      chk("t6_psc_wait", 32'(count[15:0]), 0);
    end
    cyc();
    chk("t6_first_tick", 32'(count[15:0]), 1);

    // Randomized traffic against the model
    psc = 1; mode = 2'b00; en = 2'b11;
    repeat (3000) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 63) == 0) psc = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 31) == 0) psc = 4'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) en = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) cmp = 8'($urandom_range(0, 255));
      load = {($urandom_range(0, 24) == 0), ($urandom_range(0, 24) == 0)};
      irq_ack = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      cyc();
    end
    rst = 0; load = '0; irq_ack = '0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
